port_sram_matcher: RTL and testbench

- Downstream companion of the port write frontend. It consumes `match_enable`, `new_dest_port` and `new_length`, and returns `match_end`.
- It scans all shared SRAMs one per cycle and picks the eligible SRAM with the most free pages.
- It claims the chosen SRAM through a lock handshake with the global SRAM arbiter.
- It reports the result to the frontend, and to the backend through `matched_sram`.

---
 rtl/port_sram_matcher_pkg.sv | 28 ++
 rtl/port_sram_matcher_if.sv | 36 +++
 rtl/port_sram_best_sel.sv | 49 ++++
 rtl/port_sram_matcher.sv | 176 +++++++++++++++++
 tb/tb_port_sram_matcher.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/port_sram_matcher_pkg.sv
// Shared types and constants for the port SRAM matcher.
// Holds the SRAM geometry, the matcher state encoding and the need-pages helper.
package port_sram_matcher_pkg;

   localparam int NUM_SRAM  = 32;
   localparam int IDX_W     = 5;
   localparam int PAGE_W    = 9;
   localparam int MAX_RETRY = 4;
   localparam int LEN_W     = 9;
   localparam int DEST_W    = 4;
   localparam int NEED_W    = LEN_W + 1;
   localparam int RETRY_W   = $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_LOCK,
      ST_DONE
   } match_state_e;

   // Pages of 8 words needed for a packet; one bit wider so 511 words cannot wrap.
   function automatic logic [NEED_W-1:0] need_pages(input logic [LEN_W-1:0] len);
      logic [NEED_W-1:0] sum;
      sum = {1'b0, len} + NEED_W'(7);
      return sum >> 3;
   endfunction

endpackage

// File: rtl/port_sram_matcher_if.sv
// Frontend request/result and arbiter lock handshake bundle for the matcher.
// The matcher uses the slave modport; the frontend/arbiter side uses master.
interface port_sram_matcher_if;
   import port_sram_matcher_pkg::*;

   logic                       match_enable;
   logic [DEST_W-1:0]          new_dest_port;
   logic [LEN_W-1:0]           new_length;
   logic [NUM_SRAM*PAGE_W-1:0] sram_free_pages;
   logic [NUM_SRAM-1:0]        sram_locked;
   logic                       lock_req;
   logic [IDX_W-1:0]           lock_sram;
   logic                       lock_gnt;
   logic                       lock_nack;
   logic                       match_end;
   logic                       match_suc;
   logic [IDX_W-1:0]           matched_sram;
   logic [DEST_W-1:0]          matched_dest_port;

   modport slave (
      input  match_enable, new_dest_port, new_length,
      input  sram_free_pages, sram_locked,
      input  lock_gnt, lock_nack,
      output lock_req, lock_sram,
      output match_end, match_suc, matched_sram, matched_dest_port
   );

   modport master (
      output match_enable, new_dest_port, new_length,
      output sram_free_pages, sram_locked,
      output lock_gnt, lock_nack,
      input  lock_req, lock_sram,
      input  match_end, match_suc, matched_sram, matched_dest_port
   );

endinterface

// File: rtl/port_sram_best_sel.sv
// Per-cycle eligibility test and best-candidate register for the SRAM scan.
// Ties keep the earlier candidate: replacement needs strictly more free pages.
module port_sram_best_sel
   import port_sram_matcher_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_eval,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [PAGE_W-1:0] i_free,
   input  logic              i_locked,
   input  logic [NEED_W-1:0] i_need,
   output logic              o_nxt_vld,
   output logic [IDX_W-1:0]  o_nxt_idx,
   output logic [IDX_W-1:0]  o_best_idx
);

   logic              r_best_vld;
   logic [IDX_W-1:0]  r_best_idx;
   logic [PAGE_W-1:0] r_best_free;
   logic              w_elig;
   logic              w_take;

   assign w_elig = !i_locked && (NEED_W'(i_free) >= i_need);
   assign w_take = i_eval && w_elig && (!r_best_vld || (i_free > r_best_free));

   // Look-ahead so the last scan cycle can decide using its own evaluation.
   assign o_nxt_vld  = r_best_vld || w_take;
   assign o_nxt_idx  = w_take ? i_idx : r_best_idx;
   assign o_best_idx = r_best_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_vld  <= 1'b0;
         r_best_idx  <= '0;
         r_best_free <= '0;
      end else if (i_clr) begin
         r_best_vld  <= 1'b0;
         r_best_idx  <= '0;
         r_best_free <= '0;
      end else if (w_take) begin
         r_best_vld  <= 1'b1;
         r_best_idx  <= i_idx;
         r_best_free <= i_free;
      end
   end

endmodule

// File: rtl/port_sram_matcher.sv
// Scans all shared SRAMs, picks the eligible one with most free pages and claims it.
// Optional PORT_MATCH_TIMEOUT_EN gives up after MAX_RETRY failed rounds (match_suc = 0).
module port_sram_matcher
   import port_sram_matcher_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   port_sram_matcher_if.slave bus
);

   match_state_e      r_state;
   logic              r_en_prev;
   logic [NEED_W-1:0] r_need;
   logic [DEST_W-1:0] r_dest;
   logic [IDX_W-1:0]  r_scan_ptr;
   logic [IDX_W-1:0]  r_scan_cnt;
   logic [IDX_W-1:0]  r_start_ptr;
   logic              r_lock_req;
   logic [IDX_W-1:0]  r_lock_sram;
   logic              r_match_end;
   logic              r_match_suc;
   logic [IDX_W-1:0]  r_matched_sram;
   logic [DEST_W-1:0] r_matched_dest;
`ifdef PORT_MATCH_TIMEOUT_EN
   logic [RETRY_W-1:0] r_retry;
`endif

   logic              w_rise;
   logic              w_eval;
   logic              w_clr;
   logic              w_last;
   logic              w_nxt_vld;
   logic [IDX_W-1:0]  w_nxt_idx;
   logic [IDX_W-1:0]  w_best_idx;
   logic [IDX_W-1:0]  w_ptr_inc;
   logic [IDX_W-1:0]  w_best_inc;
   logic [PAGE_W-1:0] w_free;
   logic              w_locked;

   // Only a fresh request starts a match; a level held after match_end is ignored.
   assign w_rise     = bus.match_enable && !r_en_prev;
   assign w_eval     = (r_state == ST_SCAN) && bus.match_enable;
   assign w_clr      = ((r_state == ST_IDLE) && w_rise) ||
                       ((r_state == ST_LOCK) && bus.match_enable && !bus.lock_gnt && bus.lock_nack);
   assign w_last     = (r_scan_cnt == IDX_W'(NUM_SRAM - 1));
   assign w_free     = bus.sram_free_pages[int'(r_scan_ptr)*PAGE_W +: PAGE_W];
   assign w_locked   = bus.sram_locked[r_scan_ptr];
   assign w_ptr_inc  = (r_scan_ptr == IDX_W'(NUM_SRAM - 1)) ? '0 : r_scan_ptr + 1'b1;
   assign w_best_inc = (w_best_idx == IDX_W'(NUM_SRAM - 1)) ? '0 : w_best_idx + 1'b1;

   port_sram_best_sel u_best_sel (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr),
      .i_eval     (w_eval),
      .i_idx      (r_scan_ptr),
      .i_free     (w_free),
      .i_locked   (w_locked),
      .i_need     (r_need),
      .o_nxt_vld  (w_nxt_vld),
      .o_nxt_idx  (w_nxt_idx),
      .o_best_idx (w_best_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_en_prev      <= 1'b0;
         r_need         <= '0;
         r_dest         <= '0;
         r_scan_ptr     <= '0;
         r_scan_cnt     <= '0;
         r_start_ptr    <= '0;
         r_lock_req     <= 1'b0;
         r_lock_sram    <= '0;
         r_match_end    <= 1'b0;
         r_match_suc    <= 1'b0;
         r_matched_sram <= '0;
         r_matched_dest <= '0;
`ifdef PORT_MATCH_TIMEOUT_EN
         r_retry        <= '0;
`endif
      end else begin
         r_en_prev   <= bus.match_enable;
         r_match_end <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_need     <= need_pages(bus.new_length);
                  r_dest     <= bus.new_dest_port;
                  r_scan_ptr <= r_start_ptr;
                  r_scan_cnt <= '0;
`ifdef PORT_MATCH_TIMEOUT_EN
                  r_retry    <= '0;
`endif
                  r_state    <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!bus.match_enable) begin
                  r_state <= ST_IDLE;
               end else if (!w_last) begin
                  r_scan_ptr <= w_ptr_inc;
                  r_scan_cnt <= r_scan_cnt + 1'b1;
               end else if (w_nxt_vld) begin
                  r_lock_req  <= 1'b1;
                  r_lock_sram <= w_nxt_idx;
                  r_state     <= ST_LOCK;
               end else begin
`ifdef PORT_MATCH_TIMEOUT_EN
                  if (r_retry == RETRY_W'(MAX_RETRY - 1)) begin
                     r_match_end <= 1'b1;
                     r_match_suc <= 1'b0;
                     r_state     <= ST_DONE;
                  end else begin
                     r_retry    <= r_retry + 1'b1;
                     r_scan_ptr <= r_start_ptr;
                     r_scan_cnt <= '0;
                  end
`else
                  r_scan_ptr <= r_start_ptr;
                  r_scan_cnt <= '0;
`endif
               end
            end
            ST_LOCK: begin
               if (!bus.match_enable) begin
                  r_lock_req <= 1'b0;
                  r_state    <= ST_IDLE;
               end else if (bus.lock_gnt) begin
                  // Result registers update with the pulse so they are valid alongside it.
                  r_lock_req     <= 1'b0;
                  r_match_end    <= 1'b1;
                  r_match_suc    <= 1'b1;
                  r_matched_sram <= w_best_idx;
                  r_matched_dest <= r_dest;
                  r_start_ptr    <= w_best_inc;
                  r_state        <= ST_DONE;
               end else if (bus.lock_nack) begin
                  r_lock_req <= 1'b0;
`ifdef PORT_MATCH_TIMEOUT_EN
                  if (r_retry == RETRY_W'(MAX_RETRY - 1)) begin
                     r_match_end <= 1'b1;
                     r_match_suc <= 1'b0;
                     r_state     <= ST_DONE;
                  end else begin
                     r_retry    <= r_retry + 1'b1;
                     r_scan_ptr <= r_start_ptr;
                     r_scan_cnt <= '0;
                     r_state    <= ST_SCAN;
                  end
`else
                  r_scan_ptr <= r_start_ptr;
                  r_scan_cnt <= '0;
                  r_state    <= ST_SCAN;
`endif
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.lock_req          = r_lock_req;
   assign bus.lock_sram         = r_lock_sram;
   assign bus.match_end         = r_match_end;
   assign bus.match_suc         = r_match_suc;
   assign bus.matched_sram      = r_matched_sram;
   assign bus.matched_dest_port = r_matched_dest;

endmodule

// File: tb/tb_port_sram_matcher.sv
// Randomized bench for port_sram_matcher with a scan-order reference model.
// Build with PORT_MATCH_TIMEOUT_EN defined to also exercise the give-up path.
module tb_port_sram_matcher;
   import port_sram_matcher_pkg::*;

   localparam int NO_PIN = -99;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   port_sram_matcher_if ifc ();

   port_sram_matcher dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int free_pg [NUM_SRAM];
   bit lk      [NUM_SRAM];
   bit gnt_en, nack_en;

   always_comb begin
      ifc.sram_free_pages = '0;
      ifc.sram_locked     = '0;
      for (int k = 0; k < NUM_SRAM; k++) begin
         ifc.sram_free_pages[k*PAGE_W +: PAGE_W] = PAGE_W'(free_pg[k]);
         ifc.sram_locked[k] = lk[k];
      end
   end

   assign ifc.lock_gnt  = ifc.lock_req & gnt_en;
   assign ifc.lock_nack = ifc.lock_req & nack_en;

   int checks = 0;
   int errors = 0;

   // model state
   int m_start = 0, m_matched = 0, m_mdest = 0;
   bit exp_end_ok = 0, exp_lock_ok = 0, exp_lock_vld = 0, exp_suc = 0;
   int exp_lock = 0, exp_idx = 0, exp_dest = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Largest eligible free count, first in scan order from start on ties; -1 if none.
   function automatic int model_pick(input int start, input int need);
      int best, bf, k;
      best = -1;
      bf   = 0;
      for (int i = 0; i < NUM_SRAM; i++) begin
         k = (start + i) % NUM_SRAM;
         if (!lk[k] && free_pg[k] >= need && (best < 0 || free_pg[k] > bf)) begin
            best = k;
            bf   = free_pg[k];
         end
      end
      return best;
   endfunction

   // compare process
   always @(negedge clk) begin
      if (rst_n) begin
         if (ifc.match_end) begin
            chk("end_allowed", int'(ifc.match_end), int'(exp_end_ok));
            if (exp_end_ok) begin
               chk("end_suc", int'(ifc.match_suc), int'(exp_suc));
               chk("end_sram", int'(ifc.matched_sram), exp_idx);
               chk("end_dest", int'(ifc.matched_dest_port), exp_dest);
            end
         end
         if (ifc.lock_req) begin
            chk("lock_allowed", int'(ifc.lock_req), int'(exp_lock_ok));
            if (exp_lock_ok && exp_lock_vld)
               chk("lock_sram", int'(ifc.lock_sram), exp_lock);
         end
      end
   end

   task automatic run_match(input int dest, input int len, input int pin, input int exp_lat,
                            input bit nack_first, input int unlock_k, input int unlock_cyc,
                            input bit succ);
      int need, pick, cyc;
      bit got, nacked;
      need = len / 8 + ((len % 8 != 0) ? 1 : 0);
      if (unlock_k >= 0) lk[unlock_k] = 1'b0;
      pick = model_pick(m_start, need);
      if (unlock_k >= 0) lk[unlock_k] = 1'b1;
      if (pin != NO_PIN) chk("model_pick", pick, pin);
      if (succ) begin
         exp_idx = pick; exp_dest = dest; exp_suc = 1'b1;
         exp_lock = pick; exp_lock_vld = 1'b1;
      end else begin
         exp_idx = m_matched; exp_dest = m_mdest; exp_suc = 1'b0;
         exp_lock_vld = 1'b0;
      end
      gnt_en = !nack_first;
      nack_en = nack_first;
      exp_end_ok = 1'b1;
      exp_lock_ok = 1'b1;
      @(negedge clk);
      ifc.new_dest_port = DEST_W'(dest);
      ifc.new_length    = LEN_W'(len);
      ifc.match_enable  = 1'b1;
      cyc = 1; got = 0; nacked = 0;
      while (cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (unlock_k >= 0 && cyc == unlock_cyc) lk[unlock_k] = 1'b0;
         if (ifc.match_end) begin
            got = 1;
            break;
         end
         if (nacked && nack_en) begin
            chk("nack_drop", int'(ifc.lock_req), 0);
            nack_en = 1'b0;
            gnt_en = 1'b1;
         end else if (nack_en && ifc.lock_req) begin
            nacked = 1'b1;
         end
      end
      chk("end_seen", int'(got), 1);
      if (got) begin
         if (exp_lat > 0) chk("latency", cyc, exp_lat);
         @(negedge clk);
         chk("end_pulse", int'(ifc.match_end), 0);
         if (succ) begin
            m_start = (pick + 1) % NUM_SRAM;
            m_matched = pick;
            m_mdest = dest;
         end
      end
      exp_end_ok = 1'b0;
      repeat (4) @(negedge clk);
      ifc.match_enable = 1'b0;
      @(negedge clk);
      exp_lock_ok = 1'b0;
      gnt_en = 1'b1;
      nack_en = 1'b0;
   endtask

   task automatic fill(input int val);
      for (int k = 0; k < NUM_SRAM; k++) begin
         free_pg[k] = val;
         lk[k] = 1'b0;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_lock_req"}, int'(ifc.lock_req), 0);
      chk({tag, "_lock_sram"}, int'(ifc.lock_sram), 0);
      chk({tag, "_match_end"}, int'(ifc.match_end), 0);
      chk({tag, "_match_suc"}, int'(ifc.match_suc), 0);
      chk({tag, "_matched_sram"}, int'(ifc.matched_sram), 0);
      chk({tag, "_matched_dest"}, int'(ifc.matched_dest_port), 0);
   endtask

   task automatic wait_lock_req(input string tag);
      int n;
      n = 0;
      while (!ifc.lock_req && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lock_seen"}, int'(ifc.lock_req), 1);
   endtask

   initial begin
      int len, k, need;
      rst_n = 1'b0;
      ifc.match_enable = 1'b0;
      ifc.new_dest_port = '0;
      ifc.new_length = '0;
      gnt_en = 1'b1;
      nack_en = 1'b0;
      fill(0);
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      chk("need_0", int'(need_pages(9'd0)), 0);
      chk("need_1", int'(need_pages(9'd1)), 1);
      chk("need_8", int'(need_pages(9'd8)), 1);
      chk("need_9", int'(need_pages(9'd9)), 2);
      chk("need_511", int'(need_pages(9'd511)), 64);

      // single largest SRAM, minimum latency
      fill(100);
      free_pg[7] = 200;
      run_match(6, 64, 7, NUM_SRAM + 3, 0, -1, 0, 1);

      // move the round-robin start to 10, then two tied candidates
      fill(100);
      free_pg[9] = 180;
      run_match(2, 100, 9, NUM_SRAM + 3, 0, -1, 0, 1);
      fill(100);
      free_pg[3] = 150;
      free_pg[20] = 150;
      run_match(11, 300, 20, NUM_SRAM + 3, 0, -1, 0, 1);
      run_match(12, 300, 3, NUM_SRAM + 3, 0, -1, 0, 1);

      // no candidate until SRAM 5 is unlocked mid-rescan
      fill(1);
      free_pg[5] = 2;
      lk[5] = 1'b1;
      run_match(5, 9, 5, 0, 0, 5, 40, 1);

      // refused lock, then granted on the rescan
      fill(50);
      free_pg[17] = 90;
      run_match(9, 200, 17, 2*NUM_SRAM + 4, 1, -1, 0, 1);

      // abort during SCAN
      exp_end_ok = 1'b0;
      exp_lock_ok = 1'b0;
      @(negedge clk);
      ifc.match_enable = 1'b1;
      repeat (11) @(negedge clk);
      ifc.match_enable = 1'b0;
      @(negedge clk);
      chk("abort_scan_lock_req", int'(ifc.lock_req), 0);
      repeat (50) @(negedge clk);

      // abort during LOCK
      fill(60);
      free_pg[22] = 70;
      gnt_en = 1'b0;
      exp_lock_ok = 1'b1;
      exp_lock_vld = 1'b1;
      exp_lock = model_pick(m_start, 8);
      ifc.new_length = 9'd64;
      ifc.match_enable = 1'b1;
      wait_lock_req("abort_lock");
      ifc.match_enable = 1'b0;
      @(negedge clk);
      chk("abort_lock_drop", int'(ifc.lock_req), 0);
      exp_lock_ok = 1'b0;
      repeat (40) @(negedge clk);
      gnt_en = 1'b1;
      run_match(3, 64, 22, NUM_SRAM + 3, 0, -1, 0, 1);

      // asynchronous reset while holding a lock request
      fill(30);
      free_pg[13] = 200;
      gnt_en = 1'b0;
      exp_lock_ok = 1'b1;
      exp_lock = model_pick(m_start, 1);
      ifc.new_length = 9'd5;
      ifc.match_enable = 1'b1;
      wait_lock_req("reset_lock");
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("async_reset");
      ifc.match_enable = 1'b0;
      exp_lock_ok = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      gnt_en = 1'b1;
      m_start = 0; m_matched = 0; m_mdest = 0;
      fill(100);
      free_pg[0] = 120;
      free_pg[31] = 120;
      run_match(15, 8, 0, NUM_SRAM + 3, 0, -1, 0, 1);

      // randomized matches, including zero length and exact-fit boundaries
      for (int i = 0; i < 24; i++) begin
         len = (i % 6 == 0) ? 0 : $urandom_range(1, 200);
         need = len / 8 + ((len % 8 != 0) ? 1 : 0);
         for (int j = 0; j < NUM_SRAM; j++) begin
            free_pg[j] = $urandom_range(0, 26);
            lk[j] = ($urandom_range(0, 3) == 0);
         end
         k = $urandom_range(0, NUM_SRAM - 1);
         lk[k] = 1'b0;
         if (free_pg[k] < need) free_pg[k] = need;
         run_match($urandom_range(0, 15), len, NO_PIN, NUM_SRAM + 3, 0, -1, 0, 1);
      end

`ifdef PORT_MATCH_TIMEOUT_EN
      // every SRAM owned elsewhere: give up after MAX_RETRY rounds
      fill(100);
      for (int j = 0; j < NUM_SRAM; j++) lk[j] = 1'b1;
      run_match(7, 16, -1, MAX_RETRY*NUM_SRAM + 2, 0, -1, 0, 0);
      chk("timeout_keeps_sram", int'(ifc.matched_sram), m_matched);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

endmodule
